// File: rtl/wtu_if.sv
// wtu_if: sample-in / coefficient-out handshake bundle of the wavelet scheduler
interface wtu_if #(
    parameter int WIDTH = 24,
    parameter int LVLW = 3
) ();
    logic [WIDTH-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] out_data;
    logic [LVLW-1:0] out_level;
    logic out_hp;
    logic out_valid;
    logic out_ready;
    modport master (
        output in_data, in_valid, out_ready,
        input in_ready, out_data, out_level, out_hp, out_valid
    );
    modport slave (
        input in_data, in_valid, out_ready,
        output in_ready, out_data, out_level, out_hp, out_valid
    );
endinterface

// File: rtl/wtu_sched.sv
// wtu_sched: streaming multi-level Haar decomposition sharing one butterfly across all levels
module wtu_sched #(
    parameter int WIDTH = 24,
    parameter int LEVELS = 3,
    parameter int LVLW = 3
) (
    input logic clk,
    input logic rst,
    wtu_if.slave io,
    output logic busy
);
    logic [LEVELS-1:0] half;
    logic [LEVELS:1] stage_v;
    logic signed [WIDTH-1:0] held [LEVELS];
    logic signed [WIDTH-1:0] stage [1:LEVELS];
    logic slot_free, top, emit, found, go;
    logic [LVLW-1:0] lvl;
    logic signed [WIDTH-1:0] s, prev, hpo, lpo;
    logic signed [WIDTH:0] sum, dif;

    assign slot_free = !io.out_valid || io.out_ready;
    assign top = stage_v[LEVELS];
    assign emit = top && slot_free;
    assign io.in_ready = !(|stage_v) && (!half[0] || (slot_free && !stage_v[1]));
    assign busy = |half || |stage_v || io.out_valid;

    // The highest pending stage owns the butterfly; an ineligible owner stalls everything below it.
    always_comb begin
        found = top;
        go = 1'b0;
        lvl = '0;
        s = io.in_data;
        prev = held[0];
        for (int l = LEVELS - 1; l >= 1; l--)
            if (!found && stage_v[l]) begin
                found = 1'b1;
                lvl = LVLW'(l);
                s = stage[l];
                prev = held[l];
                go = !half[l] || (slot_free && !stage_v[l+1]);
            end
        if (!found) go = io.in_valid && (!half[0] || (slot_free && !stage_v[1]));
    end

    assign sum = {prev[WIDTH-1], prev} + {s[WIDTH-1], s};
    assign dif = {prev[WIDTH-1], prev} - {s[WIDTH-1], s};
    assign lpo = sum[WIDTH:1];
    assign hpo = dif[WIDTH:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io.out_valid <= 1'b0;
            io.out_data <= '0;
            io.out_level <= '0;
            io.out_hp <= 1'b0;
            half <= '0;
            stage_v <= '0;
            for (int l = 0; l < LEVELS; l++) held[l] <= '0;
            for (int l = 1; l <= LEVELS; l++) stage[l] <= '0;
        end else begin
            if (io.out_ready) io.out_valid <= 1'b0;
            if (emit) begin
                io.out_data <= stage[LEVELS];
                io.out_hp <= 1'b0;
                io.out_level <= LVLW'(LEVELS - 1);
                io.out_valid <= 1'b1;
                stage_v[LEVELS] <= 1'b0;
            end
            for (int l = 1; l < LEVELS; l++)
                if (go && lvl == LVLW'(l)) stage_v[l] <= 1'b0;
            for (int l = 0; l < LEVELS; l++)
                if (go && lvl == LVLW'(l)) begin
                    if (half[l]) begin
                        io.out_data <= hpo;
                        io.out_hp <= 1'b1;
                        io.out_level <= lvl;
                        io.out_valid <= 1'b1;
                        stage[l+1] <= lpo;
                        stage_v[l+1] <= 1'b1;
                        half[l] <= 1'b0;
                    end else begin
                        held[l] <= s;
                        half[l] <= 1'b1;
                    end
                end
        end
    end
endmodule

// File: tb/tb_wtu_sched.sv
// tb_wtu_sched: directed scoreboard bench for a 3-level and a 1-level scheduler
module tb_wtu_sched;
    typedef struct packed {
        logic signed [23:0] d;
        logic [2:0] l;
        logic hp;
    } coef_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy_a, busy_b;
    int vec = 0;
    int miss = 0;
    coef_t qa[$];
    coef_t qb[$];
    int first_b;
    bit have_b = 1'b0;

    wtu_if #(.WIDTH(24), .LVLW(3)) a ();
    wtu_if #(.WIDTH(24), .LVLW(3)) b ();

    wtu_sched #(.WIDTH(24), .LEVELS(3), .LVLW(3)) u3 (.clk(clk), .rst(rst), .io(a), .busy(busy_a));
    wtu_sched #(.WIDTH(24), .LEVELS(1), .LVLW(3)) u1 (.clk(clk), .rst(rst), .io(b), .busy(busy_b));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic ck(input string tag, input integer got, input integer exp);
        vec++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp(input string tag, input coef_t got, input coef_t exp);
        vec++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: observed d=%0d l=%0d hp=%0d expected d=%0d l=%0d hp=%0d",
                   tag, $signed(got.d), got.l, got.hp, $signed(exp.d), exp.l, exp.hp);
        end
    endtask

    task automatic push(input bit w, input int d, input int l, input bit hp);
        coef_t c;
        c.d = 24'(d);
        c.l = 3'(l);
        c.hp = hp;
        if (w) qa.push_back(c);
        else qb.push_back(c);
    endtask

    // Reference pairing for the single-level unit: floor averages and half-differences.
    task automatic model_b(input int v);
        if (!have_b) begin
            first_b = v;
            have_b = 1'b1;
        end else begin
            push(0, (first_b - v) >>> 1, 0, 1'b1);
            push(0, (first_b + v) >>> 1, 0, 1'b0);
            have_b = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (a.out_valid && a.out_ready) begin
            vec++;
            assert (qa.size() != 0) else begin
                miss++;
                $error("FAIL a_unexpected: observed d=%0d expected no output", $signed(a.out_data));
            end
            if (qa.size() != 0) cmp("a_out", {a.out_data, a.out_level, a.out_hp}, qa.pop_front());
        end
        if (b.out_valid && b.out_ready) begin
            vec++;
            assert (qb.size() != 0) else begin
                miss++;
                $error("FAIL b_unexpected: observed d=%0d expected no output", $signed(b.out_data));
            end
            if (qb.size() != 0) cmp("b_out", {b.out_data, b.out_level, b.out_hp}, qb.pop_front());
        end
    end

    task automatic send(input bit w, input int v);
        int n = 0;
        logic ok = 1'b0;
        if (w) begin a.in_data = 24'(v); a.in_valid = 1'b1; end
        else begin b.in_data = 24'(v); b.in_valid = 1'b1; end
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = w ? a.in_ready : b.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (w) a.in_valid = 1'b0;
        else b.in_valid = 1'b0;
        vec++;
        assert (ok) else begin
            miss++;
            $error("FAIL send_timeout: observed in_ready=0 expected 1 for sample %0d", v);
        end
    endtask

    task automatic drain(input bit w, input bit cb);
        int n = 0;
        while (n < 300 && ((w ? qa.size() : qb.size()) != 0 || (cb && (w ? busy_a : busy_b)))) begin
            @(posedge clk);
            #1;
            n++;
        end
        ck(w ? "a_drain_queue" : "b_drain_queue", w ? qa.size() : qb.size(), 0);
        if (cb) ck(w ? "a_busy_idle" : "b_busy_idle", w ? busy_a : busy_b, 0);
    endtask

    initial begin
        int s[8] = '{100, -50, 7, 3, -9, 20, 11, -12};
        int idx = 0;
        int hold = 0;
        bit seen = 1'b0;
        logic acc;
        a.in_data = '0; a.in_valid = 1'b0; a.out_ready = 1'b1;
        b.in_data = '0; b.in_valid = 1'b0; b.out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        ck("rst_out_valid", a.out_valid, 0);
        ck("rst_out_data", a.out_data, 0);
        ck("rst_out_level", a.out_level, 0);
        ck("rst_out_hp", a.out_hp, 0);
        ck("rst_busy_a", busy_a, 0);
        ck("rst_busy_b", busy_b, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        push(1, 2, 0, 1); push(1, 2, 0, 1); push(1, 4, 1, 1);
        send(1, 10);
        send(1, 6);
        ck("a_in_ready_stage1", a.in_ready, 0);
        send(1, 2);
        send(1, -2);
        push(1, 0, 0, 1); push(1, 0, 0, 1); push(1, 0, 1, 1); push(1, 0, 2, 1); push(1, 4, 2, 0);
        for (int i = 0; i < 4; i++) send(1, 4);
        drain(1, 1);

        push(0, -1, 0, 1); push(0, 1, 0, 0);
        send(0, 1); send(0, 2);
        push(0, -2, 0, 1); push(0, -2, 0, 0);
        send(0, -3); send(0, 0);
        push(0, 0, 0, 1); push(0, 8388607, 0, 0);
        send(0, 8388607); send(0, 8388607);
        push(0, -8388608, 0, 1); push(0, -1, 0, 0);
        send(0, -8388608); send(0, 8388607);
        drain(0, 1);

        b.out_ready = 1'b0;
        b.in_valid = 1'b1;
        b.in_data = 24'(s[0]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b.out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    hold = $signed(b.out_data);
                end else ck("bp_stable", $signed(b.out_data), hold);
            end
            acc = b.in_ready && b.in_valid;
            if (acc) begin
                model_b(s[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            b.in_valid = idx < 8;
            if (acc && idx < 8) b.in_data = 24'(s[idx]);
        end
        b.in_valid = 1'b0;
        ck("bp_accepted_le3", int'(idx <= 3), 1);
        ck("bp_in_ready_low", b.in_ready, 0);
        ck("bp_out_valid_held", b.out_valid, 1);
        b.out_ready = 1'b1;
        for (int i = idx; i < 8; i++) begin
            model_b(s[i]);
            send(0, s[i]);
        end
        drain(0, 1);

        a.out_ready = 1'b0;
        send(1, 10); send(1, 6); send(1, 7);
        ck("pre_rst_out_valid", a.out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        ck("mid_rst_out_valid", a.out_valid, 0);
        ck("mid_rst_out_data", a.out_data, 0);
        ck("mid_rst_out_level", a.out_level, 0);
        ck("mid_rst_out_hp", a.out_hp, 0);
        ck("mid_rst_busy", busy_a, 0);
        qa.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        a.out_ready = 1'b1;
        push(1, 2, 0, 1);
        send(1, 10); send(1, 6);
        drain(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
